// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder.
// Contents: FSM state encoding, access-size codes, the latched request
// record (control_t), and a helper that flags illegal mode encodings.
package dmem_responder_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StBusy = 2'd1;
  localparam state_t StDone = 2'd2;

  // Access size, taken from mode[1:0]; mode[2] is the unsigned flag
  typedef logic [1:0] size_t;
  localparam size_t SizeByte = 2'b00;
  localparam size_t SizeHalf = 2'b01;
  localparam size_t SizeWord = 2'b10;

  // Read result returned when the backend never acknowledges
  localparam logic [31:0] TimeoutData = 32'hDEADBEEF;

  // Request as latched on the capture edge. wdata and be are already in
  // backend lane format so they stay constant for the whole access.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [2:0]  mode;
    logic        we;
    logic        both;  // read and write enables were both set
  } control_t;

  // 011 and 11x have no defined access size
  function automatic logic mode_illegal(logic [2:0] mode);
    return (mode[1:0] == 2'b11) || (mode == 3'b110);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Bus bundle between the core/backend environment and the responder.
// Core side : dmem_address, dmem_enable, dmem_write_data, dmem_write_enable,
//             dmem_write_mode, dmem_read_enable, dmem_read_mode (requests);
//             dmem_read_data, dmem_wait (responses).
// Backend   : mem_req, mem_we, mem_addr (word address), mem_wdata, mem_be
//             (outputs of the responder); mem_ack, mem_rdata (inputs).
// Status    : access_fault.
// Modports  : master = the environment driving core requests and backend
//             replies; slave = the responder itself.
interface dmem_responder_if;
  logic [31:0] dmem_address;
  logic        dmem_enable;
  logic [31:0] dmem_write_data;
  logic        dmem_write_enable;
  logic [2:0]  dmem_write_mode;
  logic        dmem_read_enable;
  logic [2:0]  dmem_read_mode;
  logic [31:0] dmem_read_data;
  logic        dmem_wait;

  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        access_fault;

  modport master (
    output dmem_address, dmem_enable, dmem_write_data, dmem_write_enable,
           dmem_write_mode, dmem_read_enable, dmem_read_mode, mem_ack, mem_rdata,
    input  dmem_read_data, dmem_wait, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           access_fault
  );

  modport slave (
    input  dmem_address, dmem_enable, dmem_write_data, dmem_write_enable,
           dmem_write_mode, dmem_read_enable, dmem_read_mode, mem_ack, mem_rdata,
    output dmem_read_data, dmem_wait, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           access_fault
  );
endinterface

// File: rtl/dmem_lane.sv
// Combinational lane logic for a single access.
// Inputs : addr (byte offset within word), mode, store_data (core write data),
//          load_raw (backend read word).
// Outputs: byte_en (backend byte enables), store_lanes (write data replicated
//          across lanes), load_data (LSB-aligned, zero-filled read value),
//          fault (misaligned or illegal mode).
module dmem_lane
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  mode,
  input  logic [31:0] store_data,
  input  logic [31:0] load_raw,
  output logic [3:0]  byte_en,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data,
  output logic        fault
);

  size_t       size;
  logic [31:0] shifted;

  assign size    = mode[1:0];
  assign shifted = load_raw >> {addr, 3'b000};

  // Sign extension is the core's job, so mode[2] only matters for legality
  always_comb begin
    byte_en     = '0;
    store_lanes = store_data;
    load_data   = shifted;
    fault       = 1'b0;
    case (size)
      SizeByte: begin
        byte_en     = 4'b0001 << addr;
        store_lanes = {4{store_data[7:0]}};
        load_data   = {24'h0, shifted[7:0]};
      end
      SizeHalf: begin
        byte_en     = 4'b0011 << {addr[1], 1'b0};
        store_lanes = {2{store_data[15:0]}};
        load_data   = {16'h0, shifted[15:0]};
        fault       = addr[0];
      end
      SizeWord: begin
        byte_en = 4'b1111;
        fault   = (addr != 2'b00);
      end
      default: fault = 1'b1;
    endcase
    if (mode_illegal(mode)) begin
      fault   = 1'b1;
      byte_en = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one core load/store at a time, drives a
// single-beat backend request until acknowledged or timed out, and returns
// formatted read data.
// Ports: clk (rising-edge clock), reset (synchronous, active high),
//        bus (slave view of dmem_responder_if: core request/response,
//        backend request/reply and access_fault).
// Parameter: TIMEOUT_CYCLES = BUSY cycles without ack before the access is
//            aborted (1..65535).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  control_t    req_q, req_d;
  logic [15:0] cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;

  logic        busy;
  logic        cap_valid;
  logic [2:0]  cap_mode;
  logic [1:0]  lane_addr;
  logic [2:0]  lane_mode;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;
  logic        lane_fault;

  assign busy      = (state_q == StBusy);
  assign cap_valid = bus.dmem_enable & (bus.dmem_read_enable | bus.dmem_write_enable);
  // A request with both enables set is a write
  assign cap_mode  = bus.dmem_write_enable ? bus.dmem_write_mode : bus.dmem_read_mode;

  // Outside BUSY the lane logic looks at the live request (capture decode);
  // inside BUSY it looks at the latched request (read formatting).
  assign lane_addr = busy ? req_q.addr[1:0] : bus.dmem_address[1:0];
  assign lane_mode = busy ? req_q.mode      : cap_mode;

  dmem_lane u_lane (
    .addr        (lane_addr),
    .mode        (lane_mode),
    .store_data  (bus.dmem_write_data),
    .load_raw    (bus.mem_rdata),
    .byte_en     (lane_be),
    .store_lanes (lane_wdata),
    .load_data   (lane_load),
    .fault       (lane_fault)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (cap_valid) begin
          req_d.addr  = bus.dmem_address;
          req_d.wdata = lane_wdata;
          req_d.be    = lane_be;
          req_d.mode  = cap_mode;
          req_d.we    = bus.dmem_write_enable;
          req_d.both  = bus.dmem_write_enable & bus.dmem_read_enable;
          cnt_d       = '0;
          if (lane_fault) begin
            // Bad accesses never reach the backend
            state_d = StDone;
            fault_d = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        // Ack is checked first so it wins over a simultaneous timeout
        if (bus.mem_ack) begin
          state_d = StDone;
          if (!req_q.we) begin
            rdata_d = lane_load;
          end else if (req_q.both) begin
            rdata_d = '0;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d = StDone;
          fault_d = 1'b1;
          if (!req_q.we) begin
            rdata_d = TimeoutData;
          end else if (req_q.both) begin
            rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      req_q   <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.mem_req        = busy;
  assign bus.dmem_wait      = busy;
  assign bus.mem_we         = req_q.we;
  assign bus.mem_addr       = req_q.addr[31:2];
  assign bus.mem_wdata      = req_q.wdata;
  assign bus.mem_be         = req_q.be;
  assign bus.access_fault   = fault_q;
  assign bus.dmem_read_data = rdata_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum backend wait cycles before abort (range 1..65535).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports dmem_address in 32, dmem_enable in 1, dmem_write_data in 32, dmem_write_enable in 1, dmem_write_mode in 3, dmem_read_enable in 1, dmem_read_mode in 3: core request, sampled only at capture edge.
REQ-005 SHALL have ports dmem_read_data out 32 (LSB-aligned, zero-filled read result) and dmem_wait out 1 (core stall).
REQ-006 SHALL have backend ports mem_req out 1, mem_we out 1, mem_addr out 30 (word address), mem_wdata out 32, mem_be out 4, mem_ack in 1, mem_rdata in 32.
REQ-007 SHALL have port access_fault out 1, one-cycle pulse on misaligned, illegal-mode or timed-out access.

Function
REQ-008 SHALL use FSM states IDLE, BUSY, DONE.
REQ-009 Capture: in IDLE or DONE, a rising edge with dmem_enable=1 and (dmem_read_enable or dmem_write_enable)=1 SHALL latch address, data, and modes, and move to BUSY.
REQ-010 SHALL ignore edges with dmem_enable=0 or with both enables 0; state goes to IDLE from DONE.
REQ-011 In BUSY: mem_req=1 and dmem_wait=1; otherwise mem_req=0 and dmem_wait=0 (combinational decode of state).
REQ-012 mem_addr, mem_we, mem_be, and mem_wdata SHALL be stable for the entire BUSY residency.
REQ-013 The first edge in BUSY with mem_ack=1 SHALL move to DONE and, for reads, register the formatted mem_rdata into dmem_read_data; minimum latency is capture edge to DONE in 2 cycles.
REQ-014 DONE SHALL last one cycle with dmem_wait=0; a new capture in that cycle (back-to-back) SHALL be legal.
REQ-015 Lane rules: byte (mode[1:0]=00) be=0001<<addr[1:0] with wdata byte replicated ×4; half (01) be=0011<<(2·addr[1]) with wdata half replicated ×2; word (10) be=1111.
REQ-016 Read format: dmem_read_data = mem_rdata >> (8·addr[1:0]), with bits above access size zeroed; modes 000/100 and 001/101 are formatted identically, because the core performs sign extension.
REQ-017 Misaligned accesses (half with addr[0]=1, word with addr[1:0]≠0) and illegal modes (011, 11x) SHALL skip BUSY: go directly to DONE, keep mem_req=0, pulse access_fault, and set dmem_read_data=0.
REQ-018 Write and read enables both set SHALL be treated as a write; dmem_read_data=0.
REQ-019 A BUSY cycle counter SHALL clear on entry; on reaching TIMEOUT_CYCLES without ack, go to DONE, pulse access_fault, and set dmem_read_data=32'hDEADBEEF (reads).
REQ-020 Ack arriving on the timeout edge SHALL win: normal completion, no fault.
REQ-021 mem_ack outside BUSY SHALL be ignored with no state or data change.
REQ-022 dmem_read_data SHALL hold its last value except at the updates defined in REQ-013, REQ-017, REQ-018 and REQ-019.

Reset
REQ-023 reset SHALL set state IDLE, dmem_read_data=0, counter=0, access_fault=0, latched request=0.
REQ-024 Reset during BUSY SHALL drop mem_req the following cycle; a later stale ack is ignored per REQ-021.

Structure
REQ-025 The state enum and access-size constants (BYTE, HALF, WORD) SHALL live in the shared types package alongside control_t.
REQ-026 Lane/format logic (be, wdata replication, read shift/mask, misalign detect) SHALL be one combinational sub-module, dmem_lane.

Verification
REQ-027 SB addr 0x1003 data 0x000000AB, ack after 3 cycles -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x400, dmem_wait high for 3 cycles.
REQ-028 LHU addr 0x2002, mem_rdata 0x1234ABCD, immediate ack -> dmem_read_data=0x00001234 in DONE, total 2 cycles.
REQ-029 LW addr 0x3001 -> no mem_req, access_fault one pulse, dmem_read_data=0, next cycle accepts a new request.
REQ-030 LW with TIMEOUT_CYCLES=4 and no ack -> DONE after 4 BUSY cycles, fault pulse, dmem_read_data=0xDEADBEEF; repeat with ack on the 4th cycle -> no fault.
REQ-031 Back-to-back: SW captured in DONE of prior LW -> BUSY with no IDLE gap; then reset asserted mid-BUSY -> mem_req=0 next cycle, a later ack causes no change.
